// File: rtl/line_mem_responder.sv
// Cache-line memory responder: one 256-bit read or write at a time, acknowledged
// with a single-cycle pulse a fixed LATENCY cycles after the request is sampled.
module line_mem_responder #(
  parameter int unsigned LATENCY = 10,
  parameter int unsigned DEPTH   = 512
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFFS_W = 5;
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx_q;
  logic                wr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   mem [DEPTH];

  logic                take;
  logic                last;
  logic                ack_next;
  logic                mem_we;
  logic                rd_load;

  // Offset bits and address bits above the line index do not select anything.
  logic unused_addr;
  assign unused_addr = ^{addr_i[OFFS_W-1:0], addr_i[ADDR_W-1:OFFS_W+IDX_W]};

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CNT_LAST) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output/control decode; the completing BUSY edge commits the access and raises ack
  always_comb begin
    take     = 1'b0;
    last     = 1'b0;
    ack_next = 1'b0;
    mem_we   = 1'b0;
    rd_load  = 1'b0;
    case (state)
      IDLE: begin
        take = enable_i;
      end
      BUSY: begin
        if (cnt == CNT_LAST) begin
          last     = 1'b1;
          ack_next = 1'b1;
          mem_we   = wr_q;
          rd_load  = ~wr_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Request latch, latency counter and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      ack_o <= ack_next;
      if (take) begin
        idx_q   <= addr_i[OFFS_W +: IDX_W];
        wr_q    <= write_i;
        wdata_q <= data_i;
        cnt     <= '0;
      end else if (state == BUSY && !last) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (rd_load) begin
        data_o <= mem[idx_q];
      end
    end
  end

  // Backing array is not cleared by reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Responder end of the cache-line memory interface: accepts one 256-bit line read or write request at a time from the data-cache initiator. Completes the request after a fixed, parameterised latency with a single-cycle acknowledge. Sits outside the CPU, on the other side of the `mem_*` port group. Models the backing data memory with cycle-accurate handshake timing.

## Interface

- `LATENCY`, default 10: cycles from request sample to `ack_o`; legal range ≥ 1.
- `DEPTH`, default 512: number of 256-bit lines; power of two.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `addr_i` in 32: byte address of the line. Bits [4:0] are ignored.
- `data_i` in 256: write line data.
- `enable_i` in 1: request valid; the initiator holds it high until `ack_o`.
- `write_i` in 1: 1 selects write, 0 selects read. Valid with `enable_i`.
- `ack_o` out 1: request complete; one-cycle pulse.
- `data_o` out 256: read line data; valid while `ack_o` is high after a read.

## Operation

- Storage: array `mem[DEPTH]` of 256 bits. Reset does not clear the array.
- Line index: `idx = addr_i[5 +: log2(DEPTH)]`. Higher address bits are ignored, so addresses wrap modulo `DEPTH` lines.
- States:
  - IDLE: `ack_o` is 0. If `enable_i` is 1 at an edge, latch `idx`, `write_i` and `data_i`, clear the counter, and go to BUSY.
  - BUSY: the counter increments each edge. When the counter equals `LATENCY-1` at an edge, go to ACK. On that same edge:
    - For a write: `mem[idx_latched] <= data_latched`.
    - For a read: `data_o <= mem[idx_latched]`.
    - In both cases: `ack_o <= 1`.
  - ACK: `ack_o` is 1 for exactly this cycle. The next edge returns to IDLE and clears `ack_o`. The request is not re-sampled on this edge.
- Only latched values are used. Changes on `addr_i`, `data_i` or `write_i` during BUSY or ACK have no effect.
- `enable_i` dropping during BUSY does not abort the request; it still completes and acks.
- Back-to-back requests: if `enable_i` is still 1 in IDLE, the cycle after ACK, it is a new request. Initiators must drop `enable_i` in the cycle after `ack_o` unless they intend a new request.
- `data_o`:
  - Updated only on a read completion.
  - Holds its value through writes and idle cycles.
  - Is 0 after reset.
- Counter width is `clog2(LATENCY)`, minimum 1 bit. It never wraps, because it is cleared on entry to BUSY.

## Timing

- Reset values: state IDLE, `ack_o` = 0, `data_o` = 0, counter = 0, latched request cleared.
- Reset applied in BUSY or ACK:
  - Return to IDLE on that edge.
  - A pending write is discarded and the array is unchanged.
  - No ack is produced.
- If `rst_i` and a completing edge coincide, reset wins.
- Latency: request sampled at edge t means `ack_o` is high between edges t+LATENCY and t+LATENCY+1. With `LATENCY` = 10, `ack_o` rises exactly 10 cycles after the sampling edge.
- With `LATENCY` = 1, the request goes IDLE → BUSY → ACK, acking one cycle after sampling.
- Throughput: at most one request per `LATENCY`+2 cycles. Minimum gap from one sampling edge to the next is `LATENCY`+2 edges.
- Read-after-write to the same line: the read sees the new data, because the write commits on the write's ack edge.
- `ack_o` and `data_o` are registered outputs, with no combinational path from inputs.
- `enable_i` high with `write_i` toggling in IDLE: the value at the sampling edge is used.

## Test plan

- Write then read: write `0x…A5A5` (256-bit pattern) to `0x0000_0040`, then read `0x0000_0040`. Each request acks after exactly 10 cycles, and the read returns the pattern on `data_o` with `ack_o`.
- Latency and pulse width: with `LATENCY` = 3, a read sampled at edge 5 gives `ack_o` high only between edges 8 and 9. `ack_o` is 0 at every other cycle in edges 0–15.
- Input churn: start a write to `0x80` with data D1. During BUSY, change the address to `0xC0` and the data to D2. Only line 4 (`0x80`) ends up holding D1, and line 6 is unchanged.
- Held enable: keep `enable_i` high across an ack. A second request is sampled on the edge after the ACK cycle, and its ack occurs `LATENCY`+2 cycles after the first ack.
- Reset mid-write: assert `rst_i` at BUSY count 5 of a write of D3 to `0x100`. There is no ack, `data_o` is 0, and a later read of `0x100` returns the old contents, not D3.
- Wrap and offset: with `DEPTH` = 512, write D4 to `0x0000_401F` (idx 0, low bits ignored). A read of `0x0000_0000` returns D4.
